wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file for the 5-stage MIPS pipeline. It consumes the MEM/WB pipeline-register outputs, selects the write-back value, and commits it to the 32×32 register file on the clock edge. It also serves the two decode-stage read ports, with optional same-cycle write-to-read bypass. This is the receiving end of the MEM/WB interface.

## Interface
Parameters:
- DATA_W, 32, register/data width
- NUM_REGS, 32, architectural registers; register 0 hardwired to zero
- CNT_W, 32, width of retired-write counter

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- aluresult  input  DATA_W  ALU result from MEM/WB
- memreadresult  input  DATA_W  load data from MEM/WB
- rd  input  5  destination register from MEM/WB
- Regwrite  input  1  write enable from MEM/WB
- MemtoReg  input  1  1 = write memreadresult, 0 = write aluresult
- rs  input  5  read address, port 1 (ID stage)
- rt  input  5  read address, port 2 (ID stage)
- readdata1  output  DATA_W  contents of rs
- readdata2  output  DATA_W  contents of rt
- wbdata  output  DATA_W  selected write-back value, for the forwarding unit
- wbvalid  output  1  Regwrite && (rd != 0)
- wbcount  output  CNT_W  count of committed register writes

## Operation
- wbdata = MemtoReg ? memreadresult : aluresult. This is combinational.
- Commit: on rising clk, if wbvalid, regs[rd] <= wbdata.
- rd == 0: no write occurs, wbvalid = 0, and wbcount is not incremented. regs[0] reads 0 at all times.
- Reads are combinational: readdata1 = regs[rs] and readdata2 = regs[rt]. Address 0 returns 0.
- wbcount increments by 1 on each committed write and wraps from 2^CNT_W−1 to 0.
- Regwrite = 0: no state changes regardless of rd, MemtoReg or data inputs.
- rs == rt is legal. Both ports return identical data.

## Timing
- Reset (rst_n low, asynchronous): all registers clear to 0 and wbcount clears to 0. readdata1, readdata2 and wbcount read 0 immediately. wbdata and wbvalid remain combinational functions of their inputs.
- Reset release is synchronous to the following clk edge. The first write is possible on the first rising edge with rst_n high.
- A reset asserted in the same cycle as a write wins: the write is discarded.
- Write latency: a value is visible in regs one clock after the cycle in which it is presented.
- Read latency: zero cycles (combinational).
- Simultaneous write and read of the same nonzero register: see Configuration.

## Configuration
- WB_BYPASS_EN defined:
  - If wbvalid && rs == rd, then readdata1 = wbdata in the same cycle. The same applies to rt and readdata2.
  - Emulates write-first-half / read-second-half, so the hazard unit need not forward from WB.
- WB_BYPASS_EN undefined:
  - Reads return the pre-edge register contents, so the old value is seen during the write cycle.
  - The forwarding unit must cover the WB→ID distance.
- Address 0 never bypasses in either mode.

## Structure
- Shared package mips_pkg holds:
  - constants DATA_W, REG_ADDR_W = 5, NUM_REGS
  - typedef reg_addr_t, 5 bits
  - typedef word_t, DATA_W bits
- One sub-module: regfile_core.
  - Contents: storage array, async reset, one write port, two combinational read ports, zero-register masking.
  - Parent contents: write-back mux, bypass logic and wbcount.

## Test plan
- Reset:
  - Stimulus: drive rst_n = 0 mid-simulation after writes.
  - Response: readdata1/readdata2 = 0 for all rs/rt, and wbcount = 0, without waiting for a clk edge.
- Write-back mux:
  - Stimulus: Regwrite = 1, rd = 5, aluresult = 0x1234, memreadresult = 0xBEEF, MemtoReg = 1; next cycle rs = 5.
  - Response: readdata1 = 0xBEEF.
  - Repeat with MemtoReg = 0: readdata1 = 0x1234.
- Zero register:
  - Stimulus: Regwrite = 1, rd = 0, aluresult = 0xFFFFFFFF.
  - Response: wbvalid = 0, readdata(rs = 0) = 0, wbcount unchanged.
- Regwrite low:
  - Stimulus: rd = 7, aluresult = 0x55, Regwrite = 0.
  - Response: regs[7] keeps its prior value and wbcount is unchanged.
- Same-cycle bypass:
  - Setup: regs[9] = 0x11.
  - Stimulus: write rd = 9, aluresult = 0x22 while rs = rt = 9.
  - Response with WB_BYPASS_EN: readdata1 = readdata2 = 0x22 in that cycle.
  - Response without WB_BYPASS_EN: readdata1 = readdata2 = 0x11, then 0x22 after the edge.
- Counter wrap:
  - Stimulus: CNT_W = 4 and 17 valid writes.
  - Response: wbcount = 1.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants and word/address types
package mips_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;
endpackage

// File: rtl/regfile_core.sv
// rtl/regfile_core.sv - architectural register storage, one write port, two combinational read ports
module regfile_core #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [4:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [4:0]        raddr1_i,
  input  logic [4:0]        raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);
  import mips_pkg::*;

  localparam reg_addr_t ZERO_REG = '0;

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Entry 0 is never written, so it stays at its reset value; reads mask it anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != ZERO_REG)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == ZERO_REG) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == ZERO_REG) ? '0 : regs_q[raddr2_i];
endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MIPS write-back stage and register file; WB_BYPASS_EN enables same-cycle write-to-read bypass
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] aluresult,
  input  logic [DATA_W-1:0] memreadresult,
  input  logic [4:0]        rd,
  input  logic              Regwrite,
  input  logic              MemtoReg,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  output logic [DATA_W-1:0] readdata1,
  output logic [DATA_W-1:0] readdata2,
  output logic [DATA_W-1:0] wbdata,
  output logic              wbvalid,
  output logic [CNT_W-1:0]  wbcount
);
  import mips_pkg::*;

  localparam reg_addr_t ZERO_REG = '0;

  logic [DATA_W-1:0] core_rdata1;
  logic [DATA_W-1:0] core_rdata2;
  logic [CNT_W-1:0]  wbcount_q;
  logic [CNT_W-1:0]  wbcount_d;

  assign wbdata  = MemtoReg ? memreadresult : aluresult;
  assign wbvalid = Regwrite && (rd != ZERO_REG);

  regfile_core #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wbvalid),
    .waddr_i  (rd),
    .wdata_i  (wbdata),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (core_rdata1),
    .rdata2_o (core_rdata2)
  );

`ifdef WB_BYPASS_EN
  // wbvalid already excludes rd == 0, so register 0 can never be bypassed.
  assign readdata1 = (wbvalid && (rs == rd)) ? wbdata : core_rdata1;
  assign readdata2 = (wbvalid && (rt == rd)) ? wbdata : core_rdata2;
`else
  assign readdata1 = core_rdata1;
  assign readdata2 = core_rdata2;
`endif

  always_comb begin
    wbcount_d = wbcount_q;
    if (wbvalid) begin
      wbcount_d = wbcount_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbcount_q <= '0;
    end else begin
      wbcount_q <= wbcount_d;
    end
  end

  assign wbcount = wbcount_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - randomized self-checking bench for wb_regfile against an array reference model
module tb_wb_regfile;
  logic        clk;
  logic        rst_n;
  logic [31:0] aluresult;
  logic [31:0] memreadresult;
  logic [4:0]  rd;
  logic        Regwrite;
  logic        MemtoReg;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] readdata1;
  logic [31:0] readdata2;
  logic [31:0] wbdata;
  logic        wbvalid;
  logic [31:0] wbcount;
  logic [31:0] readdata1_n;
  logic [31:0] readdata2_n;
  logic [31:0] wbdata_n;
  logic        wbvalid_n;
  logic [3:0]  wbcount_n;

  int checks;
  int errors;

  logic [31:0] model_regs [32];
  int unsigned model_cnt;

  wb_regfile u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .aluresult     (aluresult),
    .memreadresult (memreadresult),
    .rd            (rd),
    .Regwrite      (Regwrite),
    .MemtoReg      (MemtoReg),
    .rs            (rs),
    .rt            (rt),
    .readdata1     (readdata1),
    .readdata2     (readdata2),
    .wbdata        (wbdata),
    .wbvalid       (wbvalid),
    .wbcount       (wbcount)
  );

  wb_regfile #(.CNT_W(4)) u_dut_narrow (
    .clk           (clk),
    .rst_n         (rst_n),
    .aluresult     (aluresult),
    .memreadresult (memreadresult),
    .rd            (rd),
    .Regwrite      (Regwrite),
    .MemtoReg      (MemtoReg),
    .rs            (rs),
    .rt            (rt),
    .readdata1     (readdata1_n),
    .readdata2     (readdata2_n),
    .wbdata        (wbdata_n),
    .wbvalid       (wbvalid_n),
    .wbcount       (wbcount_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_wbdata();
    return MemtoReg ? memreadresult : aluresult;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (Regwrite && rd == addr) return exp_wbdata();
`endif
    return model_regs[addr];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    model_cnt = 0;
  endtask

  // Advance one clock edge, committing into the model as the architecture defines it.
  task automatic step();
    @(posedge clk);
    if (rst_n && Regwrite && rd != 5'd0) begin
      model_regs[rd] = exp_wbdata();
      model_cnt = model_cnt + 1;
    end
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] v);
    Regwrite = 1'b1; rd = a; aluresult = v; MemtoReg = 1'b0;
    step();
    Regwrite = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    for (int i = 0; i < 32; i += 5) begin
      rs = 5'(i); rt = 5'(31 - i);
      #1;
      checks++;
      if (readdata1 !== 32'd0 || readdata2 !== 32'd0) begin
        errors++;
        $display("FAIL reset_read rs=%0d got %h/%h exp 0", i, readdata1, readdata2);
      end
    end
    checks++;
    if (wbcount !== 32'd0 || wbcount_n !== 4'd0) begin
      errors++;
      $display("FAIL reset_count got %0d/%0d exp 0", wbcount, wbcount_n);
    end
  endtask

  task automatic test_mux();
    Regwrite = 1'b1; rd = 5'd5; aluresult = 32'h1234; memreadresult = 32'hBEEF; MemtoReg = 1'b1;
    #1;
    checks++;
    if (wbdata !== 32'hBEEF || wbvalid !== 1'b1) begin
      errors++;
      $display("FAIL mux_wbdata_mem got %h/%b exp beef/1", wbdata, wbvalid);
    end
    step();
    Regwrite = 1'b0; rs = 5'd5; #1;
    checks++;
    if (readdata1 !== 32'hBEEF) begin
      errors++;
      $display("FAIL mux_load got %h exp beef", readdata1);
    end
    Regwrite = 1'b1; MemtoReg = 1'b0;
    step();
    Regwrite = 1'b0; #1;
    checks++;
    if (readdata1 !== 32'h1234) begin
      errors++;
      $display("FAIL mux_alu got %h exp 1234", readdata1);
    end
  endtask

  task automatic test_zero_reg();
    int unsigned cnt_before;
    cnt_before = model_cnt;
    Regwrite = 1'b1; rd = 5'd0; aluresult = 32'hFFFF_FFFF; MemtoReg = 1'b0; rs = 5'd0; rt = 5'd0;
    #1;
    checks++;
    if (wbvalid !== 1'b0 || readdata1 !== 32'd0 || readdata2 !== 32'd0) begin
      errors++;
      $display("FAIL zero_same_cycle got v=%b %h/%h exp 0", wbvalid, readdata1, readdata2);
    end
    step();
    Regwrite = 1'b0; #1;
    checks++;
    if (readdata1 !== 32'd0 || wbcount !== cnt_before) begin
      errors++;
      $display("FAIL zero_after got %h cnt %0d exp 0 cnt %0d", readdata1, wbcount, cnt_before);
    end
  endtask

  task automatic test_regwrite_low();
    int unsigned cnt_before;
    write_reg(5'd7, 32'hA5A5_0007);
    cnt_before = model_cnt;
    Regwrite = 1'b0; rd = 5'd7; aluresult = 32'h55; MemtoReg = 1'b0; rs = 5'd7;
    #1;
    checks++;
    if (wbvalid !== 1'b0) begin
      errors++;
      $display("FAIL rwlow_valid got %b exp 0", wbvalid);
    end
    step();
    MemtoReg = 1'b1;
    step();
    checks++;
    if (readdata1 !== 32'hA5A5_0007 || wbcount !== cnt_before) begin
      errors++;
      $display("FAIL rwlow_hold got %h cnt %0d exp a5a50007 cnt %0d", readdata1, wbcount, cnt_before);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_now;
    write_reg(5'd9, 32'h11);
    Regwrite = 1'b1; rd = 5'd9; aluresult = 32'h22; MemtoReg = 1'b0; rs = 5'd9; rt = 5'd9;
    #1;
`ifdef WB_BYPASS_EN
    exp_now = 32'h22;
`else
    exp_now = 32'h11;
`endif
    checks++;
    if (readdata1 !== exp_now || readdata2 !== exp_now) begin
      errors++;
      $display("FAIL bypass_same_cycle got %h/%h exp %h", readdata1, readdata2, exp_now);
    end
    step();
    Regwrite = 1'b0; #1;
    checks++;
    if (readdata1 !== 32'h22 || readdata2 !== 32'h22) begin
      errors++;
      $display("FAIL bypass_after got %h/%h exp 22", readdata1, readdata2);
    end
    Regwrite = 1'b1; rd = 5'd0; aluresult = 32'h33; rs = 5'd0; rt = 5'd0; #1;
    checks++;
    if (readdata1 !== 32'd0 || readdata2 !== 32'd0) begin
      errors++;
      $display("FAIL bypass_r0 got %h/%h exp 0", readdata1, readdata2);
    end
    Regwrite = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i); rt = 5'(i ^ 5'h15);
      #0.1;
      checks++;
      if (readdata1 !== 32'd0 || readdata2 !== 32'd0) begin
        errors++;
        $display("FAIL async_reset_read addr=%0d got %h/%h exp 0", i, readdata1, readdata2);
      end
    end
    checks++;
    if (wbcount !== 32'd0 || wbcount_n !== 4'd0) begin
      errors++;
      $display("FAIL async_reset_count got %0d/%0d exp 0", wbcount, wbcount_n);
    end
    model_clear();
    Regwrite = 1'b1; rd = 5'd3; aluresult = 32'hAA; MemtoReg = 1'b0;
    step();
    rst_n = 1'b1; Regwrite = 1'b0; rs = 5'd3; #1;
    checks++;
    if (readdata1 !== 32'd0 || wbcount !== 32'd0) begin
      errors++;
      $display("FAIL reset_wins got %h cnt %0d exp 0 cnt 0", readdata1, wbcount);
    end
    write_reg(5'd3, 32'h77);
    checks++;
    if (readdata1 !== 32'h77 || wbcount !== 32'd1) begin
      errors++;
      $display("FAIL first_write_after_reset got %h cnt %0d exp 77 cnt 1", readdata1, wbcount);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      Regwrite      = ($urandom_range(0, 3) != 0);
      MemtoReg      = $urandom_range(0, 1) == 1;
      aluresult     = $urandom;
      memreadresult = $urandom;
      rd = 5'($urandom_range(0, 31));
      rs = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rt = ($urandom_range(0, 3) == 0) ? rs : 5'($urandom_range(0, 31));
      #3;
      checks++;
      if (wbdata !== exp_wbdata() || wbvalid !== (Regwrite && rd != 5'd0)) begin
        errors++;
        $display("FAIL rand_wb n=%0d got %h/%b exp %h/%b", n, wbdata, wbvalid, exp_wbdata(), Regwrite && rd != 5'd0);
      end
      checks++;
      if (readdata1 !== exp_read(rs) || readdata2 !== exp_read(rt)) begin
        errors++;
        $display("FAIL rand_read n=%0d rs=%0d rt=%0d got %h/%h exp %h/%h", n, rs, rt, readdata1, readdata2, exp_read(rs), exp_read(rt));
      end
      checks++;
      if (wbcount !== model_cnt || wbcount_n !== 4'(model_cnt % 16) || readdata1_n !== readdata1 || readdata2_n !== readdata2 || wbdata_n !== wbdata || wbvalid_n !== wbvalid) begin
        errors++;
        $display("FAIL rand_count n=%0d got %0d/%0d exp %0d/%0d", n, wbcount, wbcount_n, model_cnt, model_cnt % 16);
      end
      step();
    end
    Regwrite = 1'b0;
  endtask

  task automatic test_wrap();
    rst_n = 1'b0; #1;
    model_clear();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      write_reg(5'(1 + (i % 31)), $urandom);
    end
    #1;
    checks++;
    if (wbcount_n !== 4'd1 || wbcount !== 32'd17) begin
      errors++;
      $display("FAIL wrap got %0d/%0d exp 1/17", wbcount_n, wbcount);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    model_clear();
    rst_n = 1'b0; Regwrite = 1'b0; MemtoReg = 1'b0; rd = 5'd0; rs = 5'd0; rt = 5'd0;
    aluresult = 32'd0; memreadresult = 32'd0;
    @(posedge clk); #1;
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_mux();
    test_zero_reg();
    test_regwrite_low();
    test_bypass();
    test_random();
    test_async_reset();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
